// File: rtl/split_reg_sequencer.sv
// Command sequencer for a bank of split (two-half) registers: drives per-register
// half operations, bus_b strobes and save/restore, and sources bus_b data for INC/DEC/SWAP.
// Half-operation encoding on op_low/op_high (2 bits per register): 0 NONE, 1 READ, 2 WRITE.
module split_reg_sequencer #(
    parameter int HALF_WIDTH = 4,
    parameter int NREGS      = 4,
    parameter int RW         = $clog2(NREGS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [2:0]                      cmd_op,
    input  logic [RW-1:0]                   cmd_reg,
    input  logic [NREGS*2*HALF_WIDTH-1:0]   reg_values,
    output logic [NREGS*2-1:0]              op_low,
    output logic [NREGS*2-1:0]              op_high,
    output logic [NREGS-1:0]                bus_b_low,
    output logic [NREGS-1:0]                bus_b_high,
    output logic [NREGS-1:0]                save,
    output logic [NREGS-1:0]                restore,
    output logic [HALF_WIDTH-1:0]           bus_b_data,
    output logic                            done,
    output logic                            cmd_err
);

    localparam int W = 2 * HALF_WIDTH;

    localparam logic [1:0] REG_OP_NONE  = 2'd0;
    localparam logic [1:0] REG_OP_READ  = 2'd1;
    localparam logic [1:0] REG_OP_WRITE = 2'd2;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_STORE   = 3'd2;
    localparam logic [2:0] OP_SAVE    = 3'd3;
    localparam logic [2:0] OP_RESTORE = 3'd4;
    localparam logic [2:0] OP_INC     = 3'd5;
    localparam logic [2:0] OP_DEC     = 3'd6;
    localparam logic [2:0] OP_SWAP    = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2} state_t;

    function automatic logic [HALF_WIDTH-1:0] inc_half(input logic [HALF_WIDTH-1:0] x);
        return x + {{(HALF_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [HALF_WIDTH-1:0] dec_half(input logic [HALF_WIDTH-1:0] x);
        return x - {{(HALF_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [NREGS*2-1:0] expand_op(input logic [NREGS-1:0] m,
                                                     input logic [1:0] code);
        logic [NREGS*2-1:0] r;
        r = {NREGS{REG_OP_NONE}};
        for (int i = 0; i < NREGS; i++)
            if (m[i]) r[2*i +: 2] = code;
        return r;
    endfunction

    state_t                 state, state_nxt;
    logic [2:0]             op_p0, op_nxt;
    logic [NREGS-1:0]       mask_p0, mask_nxt;
    logic [W-1:0]           temp_p0, temp_nxt;
    logic                   two_cyc_p0, two_cyc_nxt;

    logic [NREGS*2-1:0]     op_low_nxt, op_high_nxt;
    logic [NREGS-1:0]       bus_b_low_nxt, bus_b_high_nxt, save_nxt, restore_nxt;
    logic [HALF_WIDTH-1:0]  data_nxt;
    logic                   done_nxt, err_nxt;

    logic [NREGS-1:0]       sel;
    logic [W-1:0]           slice;
    logic [HALF_WIDTH-1:0]  slice_lo;

    assign cmd_ready = (state == IDLE);

    always_comb begin
        state_nxt      = state;
        op_nxt         = op_p0;
        mask_nxt       = mask_p0;
        temp_nxt       = temp_p0;
        two_cyc_nxt    = two_cyc_p0;
        op_low_nxt     = {NREGS{REG_OP_NONE}};
        op_high_nxt    = {NREGS{REG_OP_NONE}};
        bus_b_low_nxt  = '0;
        bus_b_high_nxt = '0;
        save_nxt       = '0;
        restore_nxt    = '0;
        data_nxt       = '0;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        sel            = '0;
        slice          = '0;

        // Out-of-range indices match no register, leaving sel and slice zero.
        for (int i = 0; i < NREGS; i++)
            if (cmd_reg == RW'(i)) begin
                sel[i] = 1'b1;
                slice  = reg_values[i*W +: W];
            end
        slice_lo = slice[HALF_WIDTH-1:0];

        case (state)
            IDLE: if (cmd_valid) begin
                state_nxt   = EXEC1;
                op_nxt      = cmd_op;
                mask_nxt    = sel;
                temp_nxt    = slice;
                two_cyc_nxt = (|sel) && ((cmd_op == OP_INC && (&slice_lo)) ||
                                         (cmd_op == OP_DEC && slice_lo == '0) ||
                                         (cmd_op == OP_SWAP));
                done_nxt    = !two_cyc_nxt;
                err_nxt     = ~|sel;
                case (cmd_op)
                    OP_LOAD:    begin
                        op_low_nxt  = expand_op(sel, REG_OP_READ);
                        op_high_nxt = expand_op(sel, REG_OP_READ);
                    end
                    OP_STORE:   begin
                        op_low_nxt  = expand_op(sel, REG_OP_WRITE);
                        op_high_nxt = expand_op(sel, REG_OP_WRITE);
                    end
                    OP_SAVE:    save_nxt    = sel;
                    OP_RESTORE: restore_nxt = sel;
                    OP_INC:     begin bus_b_low_nxt  = sel; data_nxt = inc_half(slice_lo); end
                    OP_DEC:     begin bus_b_low_nxt  = sel; data_nxt = dec_half(slice_lo); end
                    OP_SWAP:    begin bus_b_high_nxt = sel; data_nxt = slice_lo; end
                    default:    ;
                endcase
                if (!(|sel)) data_nxt = '0;
            end
            // Second half of carry/borrow or swap; the command finishes here.
            EXEC1: begin
                if (two_cyc_p0) begin
                    state_nxt = EXEC2;
                    done_nxt  = 1'b1;
                    case (op_p0)
                        OP_INC:  begin bus_b_high_nxt = mask_p0; data_nxt = inc_half(temp_p0[W-1:HALF_WIDTH]); end
                        OP_DEC:  begin bus_b_high_nxt = mask_p0; data_nxt = dec_half(temp_p0[W-1:HALF_WIDTH]); end
                        OP_SWAP: begin bus_b_low_nxt  = mask_p0; data_nxt = temp_p0[W-1:HALF_WIDTH]; end
                        default: ;
                    endcase
                end else begin
                    state_nxt = IDLE;
                end
            end
            EXEC2:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_p0      <= OP_NOP;
            mask_p0    <= '0;
            temp_p0    <= '0;
            two_cyc_p0 <= 1'b0;
            op_low     <= {NREGS{REG_OP_NONE}};
            op_high    <= {NREGS{REG_OP_NONE}};
            bus_b_low  <= '0;
            bus_b_high <= '0;
            save       <= '0;
            restore    <= '0;
            bus_b_data <= '0;
            done       <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            op_p0      <= op_nxt;
            mask_p0    <= mask_nxt;
            temp_p0    <= temp_nxt;
            two_cyc_p0 <= two_cyc_nxt;
            op_low     <= op_low_nxt;
            op_high    <= op_high_nxt;
            bus_b_low  <= bus_b_low_nxt;
            bus_b_high <= bus_b_high_nxt;
            save       <= save_nxt;
            restore    <= restore_nxt;
            bus_b_data <= data_nxt;
            done       <= done_nxt;
            cmd_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_split_reg_sequencer.sv
// Directed bench for split_reg_sequencer with a small behavioural register bank
// that reacts to the controller strobes at the negedge.
module tb_split_reg_sequencer;

    localparam int HW    = 4;
    localparam int NREGS = 4;
    localparam int RW    = 3;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, STORE = 3'd2, SAVE = 3'd3,
                           RESTORE = 3'd4, INC = 3'd5, DEC = 3'd6, SWAP = 3'd7;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [2:0]             cmd_op;
    logic [RW-1:0]          cmd_reg;
    logic [NREGS*2*HW-1:0]  reg_values;
    logic [NREGS*2-1:0]     op_low, op_high;
    logic [NREGS-1:0]       bus_b_low, bus_b_high, save, restore;
    logic [HW-1:0]          bus_b_data;
    logic                   done, cmd_err;

    logic [7:0] bank [NREGS];
    logic [7:0] saved [NREGS];
    logic [7:0] load_bus;
    logic       pre_en;
    logic [1:0] pre_idx;
    logic [7:0] pre_val;

    int checks = 0;
    int errors = 0;

    split_reg_sequencer #(.HALF_WIDTH(HW), .NREGS(NREGS), .RW(RW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_reg(cmd_reg), .reg_values(reg_values),
        .op_low(op_low), .op_high(op_high), .bus_b_low(bus_b_low),
        .bus_b_high(bus_b_high), .save(save), .restore(restore),
        .bus_b_data(bus_b_data), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always_comb reg_values = {bank[3], bank[2], bank[1], bank[0]};

    // Register bank: consumes controls at the negedge inside each execute cycle.
    always @(negedge clk) begin
        if (pre_en) bank[pre_idx] <= pre_val;
        for (int i = 0; i < NREGS; i++) begin
            if (op_low[2*i +: 2] == 2'd1)  bank[i][3:0] <= load_bus[3:0];
            if (op_high[2*i +: 2] == 2'd1) bank[i][7:4] <= load_bus[7:4];
            if (bus_b_low[i])              bank[i][3:0] <= bus_b_data;
            if (bus_b_high[i])             bank[i][7:4] <= bus_b_data;
            if (save[i])                   saved[i]     <= bank[i];
            if (restore[i])                bank[i]      <= saved[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] ol, input logic [7:0] oh,
                              input logic [3:0] bl, input logic [3:0] bh,
                              input logic [3:0] sv, input logic [3:0] rs,
                              input logic [3:0] d, input logic dn, input logic er,
                              input logic rdy);
        chk({tag, ".op_low"},     32'(op_low),     32'(ol));
        chk({tag, ".op_high"},    32'(op_high),    32'(oh));
        chk({tag, ".bus_b_low"},  32'(bus_b_low),  32'(bl));
        chk({tag, ".bus_b_high"}, 32'(bus_b_high), 32'(bh));
        chk({tag, ".save"},       32'(save),       32'(sv));
        chk({tag, ".restore"},    32'(restore),    32'(rs));
        chk({tag, ".bus_b_data"}, 32'(bus_b_data), 32'(d));
        chk({tag, ".done"},       32'(done),       32'(dn));
        chk({tag, ".cmd_err"},    32'(cmd_err),    32'(er));
        chk({tag, ".cmd_ready"},  32'(cmd_ready),  32'(rdy));
    endtask

    task automatic preload(input logic [1:0] idx, input logic [7:0] val);
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        @(negedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Ends 1ns into the first execute cycle.
    task automatic send(input string tag, input logic [2:0] op, input logic [RW-1:0] r);
        chk({tag, ".ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_reg   = r;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_reg   = '0;
        load_bus  = 8'h00;
        pre_en    = 1'b0;
        pre_idx   = '0;
        pre_val   = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        preload(2'd0, 8'h5C);
        preload(2'd1, 8'h3A);
        preload(2'd2, 8'h00);
        preload(2'd3, 8'h12);

        // STORE reg 2
        send("store", STORE, 3'd2);
        expect_out("store.e1", 8'h20, 8'h20, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("store.idle", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Reset asserted during EXEC1 of STORE
        send("store_rst", STORE, 3'd2);
        rst = 1'b1;
        #1;
        expect_out("rst_mid", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        step();
        expect_out("rst_after", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Reset during EXEC1 of SWAP abandons EXEC2
        send("swap_rst", SWAP, 3'd0);
        rst = 1'b1;
        #3 rst = 1'b0;
        step();
        expect_out("swap_rst.after", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("swap_rst.reg0", 32'(bank[0]), 32'h5C);

        // INC 0x3A, single cycle
        send("inc3a", INC, 3'd1);
        expect_out("inc3a.e1", 8'h00, 8'h00, 4'b0010, 4'h0, 4'h0, 4'h0, 4'hB, 1'b1, 1'b0, 1'b0);
        step();
        chk("inc3a.ready", 32'(cmd_ready), 32'd1);
        chk("inc3a.reg1", 32'(bank[1]), 32'h3B);

        // INC 0x2F, carry into high half
        preload(2'd1, 8'h2F);
        send("inc2f", INC, 3'd1);
        expect_out("inc2f.e1", 8'h00, 8'h00, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("inc2f.e2", 8'h00, 8'h00, 4'h0, 4'b0010, 4'h0, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0);
        step();
        chk("inc2f.ready", 32'(cmd_ready), 32'd1);
        chk("inc2f.reg1", 32'(bank[1]), 32'h30);

        // INC 0xFF wraps to 0x00
        preload(2'd1, 8'hFF);
        send("incff", INC, 3'd1);
        expect_out("incff.e1", 8'h00, 8'h00, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("incff.e2", 8'h00, 8'h00, 4'h0, 4'b0010, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk("incff.reg1", 32'(bank[1]), 32'h00);

        // DEC 0x40 borrows
        preload(2'd2, 8'h40);
        send("dec40", DEC, 3'd2);
        expect_out("dec40.e1", 8'h00, 8'h00, 4'b0100, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("dec40.e2", 8'h00, 8'h00, 4'h0, 4'b0100, 4'h0, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0);
        step();
        chk("dec40.reg2", 32'(bank[2]), 32'h3F);

        // DEC 0x00 wraps to 0xFF
        preload(2'd2, 8'h00);
        send("dec00", DEC, 3'd2);
        expect_out("dec00.e1", 8'h00, 8'h00, 4'b0100, 4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("dec00.e2", 8'h00, 8'h00, 4'h0, 4'b0100, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
        step();
        chk("dec00.reg2", 32'(bank[2]), 32'hFF);

        // SWAP 0x5C -> 0xC5, cmd_valid held high through execution
        send("swap", SWAP, 3'd0);
        cmd_valid = 1'b1;
        cmd_op    = STORE;
        expect_out("swap.e1", 8'h00, 8'h00, 4'h0, 4'b0001, 4'h0, 4'h0, 4'hC, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("swap.e2", 8'h00, 8'h00, 4'b0001, 4'h0, 4'h0, 4'h0, 4'h5, 1'b1, 1'b0, 1'b0);
        cmd_valid = 1'b0;
        step();
        expect_out("swap.idle", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("swap.reg0", 32'(bank[0]), 32'hC5);

        // SAVE, LOAD 0x99, RESTORE on reg 3
        send("save", SAVE, 3'd3);
        expect_out("save.e1", 8'h00, 8'h00, 4'h0, 4'h0, 4'b1000, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        load_bus = 8'h99;
        send("load", LOAD, 3'd3);
        expect_out("load.e1", 8'h40, 8'h40, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk("load.reg3", 32'(bank[3]), 32'h99);
        send("restore", RESTORE, 3'd3);
        expect_out("restore.e1", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk("restore.reg3", 32'(bank[3]), 32'h12);

        // Out-of-range index
        send("oor", INC, 3'd4);
        expect_out("oor.e1", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("oor.idle", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // NOP
        send("nop", NOP, 3'd1);
        expect_out("nop.e1", 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk("nop.reg1", 32'(bank[1]), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
